usb_rx_data_check: RTL and testbench

//  Receive-side checker for USB DATA packet payloads. Sits after the PID stripper and consumes the

---
 rtl/usb_rx_data_check_if.sv | 31 +++
 rtl/usb_rx_data_check.sv | 165 ++++++++++++++++
 tb/tb_usb_rx_data_check.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_data_check_if.sv
// Byte-stream and packet-status bundle for the USB DATA payload checker.
// master drives received bytes, slave is the checker.
interface usb_rx_data_check_if #(
    parameter int LEN_W = 11
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_abort;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             pkt_done;
    logic             pkt_ok;
    logic             err_crc;
    logic             err_short;
    logic             err_len;
    logic             err_abort;
    logic [LEN_W-1:0] pkt_len;

    modport master (
        output in_data, in_valid, in_last, in_abort,
        input  out_data, out_valid, pkt_done, pkt_ok,
        input  err_crc, err_short, err_len, err_abort, pkt_len
    );

    modport slave (
        input  in_data, in_valid, in_last, in_abort,
        output out_data, out_valid, pkt_done, pkt_ok,
        output err_crc, err_short, err_len, err_abort, pkt_len
    );
endinterface

// File: rtl/usb_rx_data_check.sv
// USB DATA payload checker: CRC16 residual check over payload+CRC,
// payload forwarded through a 2-byte holdback, per-packet status.
module usb_rx_data_check #(
    parameter int MAX_LEN = 1023,
    parameter int LEN_W   = 11
) (
    input logic                clk,
    input logic                rst_n,
    usb_rx_data_check_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ONE,
        STREAM
    } state_t;

    localparam logic [15:0]      CRC_INIT  = 16'hFFFF;
    localparam logic [15:0]      CRC_RESID = 16'hB001;
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);

    state_t           state, state_d;
    logic [7:0]       h0, h0_d, h1, h1_d;
    logic [15:0]      crc, crc_d, crc_nxt;
    logic [LEN_W-1:0] cnt, cnt_d, cnt_new;
    logic [7:0]       out_data, out_data_d;
    logic             out_valid, out_valid_d;
    logic             pkt_done, pkt_done_d;
    logic             pkt_ok, pkt_ok_d;
    logic             err_crc, err_crc_d;
    logic             err_short, err_short_d;
    logic             err_len, err_len_d;
    logic             err_abort, err_abort_d;
    logic [LEN_W-1:0] pkt_len, pkt_len_d;

    // Reflected CRC16 (poly 0xA001), one whole byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state, holdback shifting, forwarding and status decisions.
    always_comb begin
        crc_nxt     = crc16_byte(crc, bus.in_data);
        state_d     = state;
        h0_d        = h0;
        h1_d        = h1;
        crc_d       = crc;
        cnt_d       = cnt;
        cnt_new     = cnt;
        out_data_d  = out_data;
        out_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_ok_d    = pkt_ok;
        err_crc_d   = err_crc;
        err_short_d = err_short;
        err_len_d   = err_len;
        err_abort_d = err_abort;
        pkt_len_d   = pkt_len;
        if (bus.in_abort) begin
            // Abort wins over any byte this cycle; idle aborts are ignored.
            if (state != IDLE) begin
                pkt_done_d  = 1'b1;
                pkt_ok_d    = 1'b0;
                err_crc_d   = 1'b0;
                err_short_d = 1'b0;
                err_len_d   = 1'b0;
                err_abort_d = 1'b1;
                pkt_len_d   = cnt;
                state_d     = IDLE;
                crc_d       = CRC_INIT;
                cnt_d       = '0;
            end
        end else if (bus.in_valid) begin
            crc_d = crc_nxt;
            unique case (state)
                IDLE: begin
                    h0_d    = bus.in_data;
                    state_d = ONE;
                end
                ONE: begin
                    h1_d    = bus.in_data;
                    state_d = STREAM;
                end
                default: begin
                    h0_d = h1;
                    h1_d = bus.in_data;
                    // Past MAX_LEN the count pins at MAX_LEN+1 and
                    // forwarding stops for the rest of the packet.
                    if (cnt < LEN_MAX) begin
                        out_data_d  = h0;
                        out_valid_d = 1'b1;
                        cnt_new     = cnt + 1'b1;
                    end else begin
                        cnt_new = LEN_SAT;
                    end
                    cnt_d = cnt_new;
                end
            endcase
            if (bus.in_last) begin
                pkt_done_d  = 1'b1;
                err_short_d = (state == IDLE);
                err_crc_d   = (state != IDLE) && (crc_nxt != CRC_RESID);
                err_len_d   = (cnt_new == LEN_SAT);
                err_abort_d = 1'b0;
                pkt_ok_d    = (state != IDLE) && (crc_nxt == CRC_RESID)
                              && (cnt_new != LEN_SAT);
                pkt_len_d   = cnt_new;
                state_d     = IDLE;
                crc_d       = CRC_INIT;
                cnt_d       = '0;
            end
        end
    end

    // State, holdback, CRC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h0        <= '0;
            h1        <= '0;
            crc       <= CRC_INIT;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            err_crc   <= 1'b0;
            err_short <= 1'b0;
            err_len   <= 1'b0;
            err_abort <= 1'b0;
            pkt_len   <= '0;
        end else begin
            state     <= state_d;
            h0        <= h0_d;
            h1        <= h1_d;
            crc       <= crc_d;
            cnt       <= cnt_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            pkt_done  <= pkt_done_d;
            pkt_ok    <= pkt_ok_d;
            err_crc   <= err_crc_d;
            err_short <= err_short_d;
            err_len   <= err_len_d;
            err_abort <= err_abort_d;
            pkt_len   <= pkt_len_d;
        end
    end

    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.pkt_done  = pkt_done;
    assign bus.pkt_ok    = pkt_ok;
    assign bus.err_crc   = err_crc;
    assign bus.err_short = err_short;
    assign bus.err_len   = err_len;
    assign bus.err_abort = err_abort;
    assign bus.pkt_len   = pkt_len;
endmodule

// File: tb/tb_usb_rx_data_check.sv
// Scoreboard bench for usb_rx_data_check: two instances (MAX_LEN 1023
// and 4) see the same byte stream; a monitor checks each against its queue.
module tb_usb_rx_data_check;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    usb_rx_data_check_if #(.LEN_W(11)) bus0 ();
    usb_rx_data_check_if #(.LEN_W(11)) bus1 ();

    usb_rx_data_check #(.MAX_LEN(1023), .LEN_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    usb_rx_data_check #(.MAX_LEN(4), .LEN_W(11)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic        ok;
        logic        ecrc;
        logic        eshort;
        logic        elen;
        logic        eabort;
        logic [10:0] len;
    } st_t;

    logic [7:0] pkt[$];
    logic [7:0] bq0[$], bq1[$];
    st_t        sq0[$], sq1[$];
    int         checks = 0;
    int         passes = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got %h required %h", name, got, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // CRC-16/USB of the first n bytes of pkt, bit-serial, final inversion.
    function automatic logic [15:0] crc16_usb(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ pkt[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    // Expected outcome for each instance: kind 0 = ends with last,
    // 1 = aborted after the bytes, 2 = reset after the bytes.
    task automatic model(input int kind);
        int          n;
        int          p;
        int          mx;
        st_t         e;
        logic [15:0] c;
        n = pkt.size();
        p = (n >= 2) ? n - 2 : 0;
        for (int w = 0; w < 2; w++) begin
            mx = (w == 0) ? 1023 : 4;
            e  = '0;
            if (!(kind == 0 && n == 1)) begin
                for (int i = 0; i < imin(p, mx); i++) begin
                    if (w == 0) bq0.push_back(pkt[i]);
                    else bq1.push_back(pkt[i]);
                end
            end
            if (kind == 0) begin
                if (n == 1) begin
                    e.eshort = 1'b1;
                end else begin
                    c      = crc16_usb(p);
                    e.ecrc = (c != {pkt[n-1], pkt[n-2]});
                    e.elen = (p > mx);
                    e.len  = 11'(imin(p, mx + 1));
                    e.ok   = !e.ecrc && !e.elen;
                end
            end else if (kind == 1) begin
                e.eabort = 1'b1;
                e.len    = 11'(imin(p, mx + 1));
            end
            if (kind != 2) begin
                if (w == 0) sq0.push_back(e);
                else sq1.push_back(e);
            end
        end
    endtask

    task automatic set_in(input logic [7:0] d, input logic v,
                          input logic l, input logic a);
        bus0.in_data = d; bus0.in_valid = v;
        bus0.in_last = l; bus0.in_abort = a;
        bus1.in_data = d; bus1.in_valid = v;
        bus1.in_last = l; bus1.in_abort = a;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            set_in(8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic build(input int p, input bit bad);
        logic [15:0] c;
        pkt.delete();
        for (int i = 0; i < p; i++) pkt.push_back(8'($urandom_range(0, 255)));
        c = crc16_usb(p);
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
        if (bad) pkt[p] = pkt[p] ^ 8'h01;
    endtask

    task automatic load_123(input logic [7:0] c0, input logic [7:0] c1);
        pkt.delete();
        for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
        pkt.push_back(c0);
        pkt.push_back(c1);
    endtask

    function automatic logic [25:0] outs(input int w);
        if (w == 0)
            return {bus0.out_data, bus0.out_valid, bus0.pkt_done, bus0.pkt_ok,
                    bus0.err_crc, bus0.err_short, bus0.err_len, bus0.err_abort,
                    bus0.pkt_len};
        return {bus1.out_data, bus1.out_valid, bus1.pkt_done, bus1.pkt_ok,
                bus1.err_crc, bus1.err_short, bus1.err_len, bus1.err_abort,
                bus1.pkt_len};
    endfunction

    task automatic send(input int kind, input bit bub);
        int n;
        n = pkt.size();
        model(kind);
        for (int i = 0; i < n; i++) begin
            if (bub && i > 0 && $urandom_range(0, 3) == 0)
                idle($urandom_range(1, 2));
            @(negedge clk);
            set_in(pkt[i], 1'b1, 1'(kind == 0 && i == n - 1), 1'b0);
        end
        if (kind == 1) begin
            @(negedge clk);
            set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end else if (kind == 2) begin
            idle(3);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_mid0", 32'(outs(0)), 32'h0);
            check("rst_mid1", 32'(outs(1)), 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    // Monitor: pop and compare whenever an instance presents output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.out_valid) begin
                if (bq0.size() == 0) check("byte0_extra", 32'(bus0.out_data), 32'hFFFF);
                else check("byte0", 32'(bus0.out_data), 32'(bq0.pop_front()));
            end
            if (bus1.out_valid) begin
                if (bq1.size() == 0) check("byte1_extra", 32'(bus1.out_data), 32'hFFFF);
                else check("byte1", 32'(bus1.out_data), 32'(bq1.pop_front()));
            end
            if (bus0.pkt_done) begin
                if (sq0.size() == 0) check("done0_extra", 32'(outs(0)), 32'hFFFF);
                else check("status0", 32'(outs(0) & 26'h0FFFF),
                           32'(sq0.pop_front()));
            end
            if (bus1.pkt_done) begin
                if (sq1.size() == 0) check("done1_extra", 32'(outs(1)), 32'hFFFF);
                else check("status1", 32'(outs(1) & 26'h0FFFF),
                           32'(sq1.pop_front()));
            end
        end
    end

    initial begin
        int k;
        set_in(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset0", 32'(outs(0)), 32'h0);
        check("reset1", 32'(outs(1)), 32'h0);
        rst_n = 1'b1;
        idle(2);

        load_123(8'hC8, 8'hB4); send(0, 1'b0); idle(3);
        load_123(8'hC8, 8'hB5); send(0, 1'b0); idle(3);
        pkt.delete(); pkt.push_back(8'h00); pkt.push_back(8'h00);
        send(0, 1'b0); idle(3);
        pkt.delete(); pkt.push_back(8'h5A); send(0, 1'b0); idle(3);
        build(6, 1'b0); send(0, 1'b0); idle(3);
        build(6, 1'b0); while (pkt.size() > 5) void'(pkt.pop_back());
        send(1, 1'b0);
        load_123(8'hC8, 8'hB4); send(0, 1'b0);
        load_123(8'hC8, 8'hB4); send(0, 1'b0); idle(3);

        for (int t = 0; t < 60; t++) begin
            k = $urandom_range(0, 9);
            build($urandom_range(0, 12), k == 0);
            if (k == 1) begin
                while (pkt.size() > 1 && $urandom_range(0, 2) != 0)
                    void'(pkt.pop_back());
                send(1, 1'b1);
            end else begin
                send(0, 1'b1);
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        build(9, 1'b0); while (pkt.size() > 7) void'(pkt.pop_back());
        send(2, 1'b0);
        idle(1);
        load_123(8'hC8, 8'hB4); send(0, 1'b1);
        idle(6);

        check("left_b0", 32'(bq0.size()), 32'h0);
        check("left_b1", 32'(bq1.size()), 32'h0);
        check("left_s0", 32'(sq0.size()), 32'h0);
        check("left_s1", 32'(sq1.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
